// File: rtl/program_loader.sv
// Boot loader: assembles a framed big-endian byte stream into instruction words, writes them from
// address 0 and releases cpu_rst only after a checksum-verified load. Optional idle timeout: LOADER_TIMEOUT_EN.
module program_loader #(
  parameter int MAX_WORDS      = 256,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERROR} state_t;

  state_t      state, state_next;
  logic [15:0] len;
  logic [23:0] word_buf;
  logic [1:0]  byte_idx;
  logic [7:0]  checksum;
  logic [16:0] len_new;
  logic        accept, load_start, timed_out;

  // All status outputs decode straight from the state register, so reset takes effect immediately.
  assign byte_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA) || (state == CHECK);
  assign imem_we    = (state == WRITE);
  assign done       = (state == DONE);
  assign error      = (state == ERROR);
  assign busy       = !((state == IDLE) || (state == DONE) || (state == ERROR));
  assign cpu_rst    = (state != DONE);
  assign accept     = byte_valid && byte_ready;
  assign load_start = start && !busy;
  assign len_new    = {1'b0, len[15:8], byte_data};

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      idle_cnt <= '0;
    else if (load_start || accept)
      idle_cnt <= '0;
    else if (byte_ready)
      idle_cnt <= idle_cnt + 1'b1;
  end

  // Fires on the cycle the counter would reach the limit, so ERROR is entered on that same edge.
  assign timed_out = byte_ready && !accept && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERROR: if (start) state_next = LEN_HI;
      LEN_HI: if (accept) state_next = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if (len_new > 17'(MAX_WORDS))
            state_next = ERROR;
          else if (len_new == 17'd0)
            state_next = CHECK;
          else
            state_next = DATA;
        end
      end
      DATA: if (accept && byte_idx == 2'd3) state_next = WRITE;
      WRITE: state_next = (word_count + 16'd1 == len) ? CHECK : DATA;
      CHECK: if (accept) state_next = (byte_data == checksum) ? DONE : ERROR;
      default: state_next = IDLE;
    endcase
    if (timed_out) state_next = ERROR;
  end

  // Frame datapath; the imem address/data registers only change when a word completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len        <= '0;
      word_buf   <= '0;
      byte_idx   <= '0;
      checksum   <= '0;
      word_count <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      if (load_start) begin
        word_count <= '0;
        checksum   <= '0;
        byte_idx   <= '0;
      end
      if (accept && state == LEN_HI) len[15:8] <= byte_data;
      if (accept && state == LEN_LO) len[7:0] <= byte_data;
      if (accept && state == DATA) begin
        word_buf <= {word_buf[15:0], byte_data};
        checksum <= checksum ^ byte_data;
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) begin
          imem_wdata <= {word_buf, byte_data};
          imem_addr  <= {14'd0, word_count, 2'b00};
        end
      end
      if (state == WRITE) word_count <= word_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: random and directed frames checked against a frame-level model.
// Exercises the idle timeout only when LOADER_TIMEOUT_EN is defined.
module tb_program_loader;

  localparam int MAX_WORDS      = 256;
  localparam int TIMEOUT_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, imem_we, cpu_rst, busy, done, error;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] word_count;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] words_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  program_loader #(.MAX_WORDS(MAX_WORDS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Every write strobe must match the next expected (address, word) pair in order.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      checkOutput("ready_during_write", byte_ready, 0);
      checkOutput("write_expected", exp_addr_q.size() != 0, 1);
      if (exp_addr_q.size() != 0) begin
        checkOutput("imem_addr", imem_addr, exp_addr_q.pop_front());
        checkOutput("imem_wdata", imem_wdata, exp_data_q.pop_front());
      end
    end
  end

  task automatic sendByte(input logic [7:0] b, input int valid_pct);
    bit ok = 0;
    bit ready_s;
    for (int waited = 0; waited < 200 && !ok; waited++) begin
      @(negedge clk);
      byte_data  = b;
      byte_valid = ($urandom_range(99) < valid_pct);
      start      = busy && ($urandom_range(7) == 0);
      ready_s    = byte_ready;
      @(posedge clk);
      if (byte_valid && ready_s) ok = 1;
    end
    if (!ok) checkOutput("byte_accept_timeout", ok, 1);
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start      = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("cpu_rst_held", cpu_rst, 1);
    checkOutput("count_cleared", word_count, 0);
  endtask

  task automatic fillRandom(input int n);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back($urandom);
  endtask

  // Sends a whole frame of n_decl words from words_q; ck_flip corrupts the checksum byte.
  task automatic applyStimulus(input int n_decl, input logic [7:0] ck_flip, input int valid_pct);
    logic [7:0]  ck = 8'h00;
    logic [15:0] n16 = 16'(n_decl);
    logic [31:0] w;
    bit          oversize = (n_decl > MAX_WORDS);
    bit          exp_done = !oversize && (ck_flip == 8'h00);
    int          cyc = 0;
    exp_addr_q.delete();
    exp_data_q.delete();
    pulseStart();
    sendByte(n16[15:8], valid_pct);
    sendByte(n16[7:0], valid_pct);
    if (!oversize) begin
      for (int i = 0; i < n_decl; i++) begin
        w = words_q[i];
        exp_addr_q.push_back(32'(i * 4));
        exp_data_q.push_back(w);
        for (int k = 3; k >= 0; k--) begin
          ck ^= w[k*8 +: 8];
          sendByte(w[k*8 +: 8], valid_pct);
        end
      end
      sendByte(ck ^ ck_flip, valid_pct);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
    while (!(done || error) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("done", done, exp_done);
    checkOutput("error", error, !exp_done);
    checkOutput("cpu_rst", cpu_rst, !exp_done);
    checkOutput("busy_end", busy, 0);
    checkOutput("ready_end", byte_ready, 0);
    checkOutput("word_count", word_count, oversize ? 0 : n_decl);
    checkOutput("writes_outstanding", exp_addr_q.size(), 0);
  endtask

  initial begin
    int n;
    int cyc;
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cpu_rst", cpu_rst, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_we", imem_we, 0);
    checkOutput("rst_ready", byte_ready, 0);
    checkOutput("rst_count", word_count, 0);
    checkOutput("rst_addr", imem_addr, 0);
    checkOutput("rst_wdata", imem_wdata, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset mid-stream");
    exp_addr_q.delete();
    exp_data_q.delete();
    pulseStart();
    sendByte(8'h00, 100);
    sendByte(8'h01, 100);
    sendByte(8'h11, 100);
    sendByte(8'h22, 100);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    #1;
    checkOutput("midrst_cpu_rst", cpu_rst, 1);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_we", imem_we, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postrst_ready", byte_ready, 0);
    checkOutput("postrst_busy", busy, 0);
    checkOutput("postrst_count", word_count, 0);
    byte_valid = 1'b0;

    $display("[TB] directed frames");
    words_q = '{32'hDEADBEEF, 32'h00000001};
    applyStimulus(2, 8'h00, 70);
    words_q = '{32'hDEADBEEF, 32'h00000001};
    applyStimulus(2, 8'h07, 70);
    applyStimulus(257, 8'h00, 100);
    words_q.delete();
    applyStimulus(0, 8'h00, 100);
    fillRandom(3);
    applyStimulus(3, 8'h00, 100);

    $display("[TB] random frames");
    for (int t = 0; t < 12; t++) begin
      n = ($urandom_range(5) == 0) ? 257 + $urandom_range(2000) : $urandom_range(0, 6);
      fillRandom(n > MAX_WORDS ? 0 : n);
      applyStimulus(n, ($urandom_range(3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                    $urandom_range(30, 100));
    end

`ifdef LOADER_TIMEOUT_EN
    $display("[TB] idle timeout");
    pulseStart();
    sendByte(8'h00, 100);
    sendByte(8'h01, 100);
    sendByte(8'hDE, 100);
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
    cyc        = 0;
    while (!error && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("timeout_cycles", cyc, TIMEOUT_CYCLES);
    checkOutput("timeout_cpu_rst", cpu_rst, 1);
    checkOutput("timeout_done", done, 0);
    fillRandom(2);
    applyStimulus(2, 8'h00, 100);
`else
    cyc = 0;
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
